// File: rtl/tile_row_packer.sv
// Packs a stream of buffer words into LANES-wide rows, flushing a partial
// final row when the tile reader signals read-done.
module tile_row_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_reg_clear,
  input  logic                          i_valid,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [ADDR_WIDTH-1:0]         i_data_addr,
  input  logic                          i_last,
  output logic                          o_ready,
  output logic                          o_row_valid,
  input  logic                          i_row_ready,
  output logic [LANES*DATA_WIDTH-1:0]   o_row_data,
  output logic [LANES-1:0]              o_row_mask,
  output logic [ADDR_WIDTH-1:0]         o_row_base_addr,
  output logic                          o_row_last,
  output logic                          o_done,
  output logic                          o_overflow
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           lane_cnt;
  logic                       last_pend;
  logic [LANES*DATA_WIDTH-1:0] row_data;
  logic [LANES-1:0]           row_mask;
  logic [ADDR_WIDTH-1:0]      base_addr;
  logic                       row_last;
  logic                       done;
  logic                       overflow;

  logic word_wr, row_full, eff_last, to_hold, empty_done, accept;

  // A read-done seen while holding a row is replayed on the first FILL cycle.
  always_comb begin
    state_nxt  = state;
    word_wr    = 1'b0;
    row_full   = 1'b0;
    eff_last   = 1'b0;
    to_hold    = 1'b0;
    empty_done = 1'b0;
    accept     = 1'b0;
    if (state == FILL) begin
      word_wr    = i_valid;
      row_full   = i_valid && (lane_cnt == LAST_LANE);
      eff_last   = i_last || last_pend;
      to_hold    = row_full || (eff_last && (i_valid || lane_cnt != '0));
      empty_done = eff_last && !i_valid && (lane_cnt == '0);
      if (to_hold) state_nxt = HOLD;
    end else begin
      accept = i_row_ready;
      if (accept) state_nxt = FILL;
    end
  end

  // NOTE: the synchronous clear shares the reset branch so both paths leave
  // every register in exactly the same state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= FILL;
    end else if (i_reg_clear) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the row buffer drives outputs directly, so it is reset like any
  // other register rather than left as uninitialised storage.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      lane_cnt  <= '0;
      last_pend <= 1'b0;
      row_data  <= '0;
      row_mask  <= '0;
      base_addr <= '0;
      row_last  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else if (i_reg_clear) begin
      lane_cnt  <= '0;
      last_pend <= 1'b0;
      row_data  <= '0;
      row_mask  <= '0;
      base_addr <= '0;
      row_last  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FILL) begin
        last_pend <= 1'b0;
        if (word_wr) begin
          row_data[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= i_data;
          row_mask[lane_cnt] <= 1'b1;
          if (lane_cnt == '0) base_addr <= i_data_addr;
          lane_cnt <= row_full ? '0 : lane_cnt + 1'b1;
        end
        if (to_hold) begin
          lane_cnt <= '0;
          row_last <= eff_last;
        end
        if (empty_done) done <= 1'b1;
      end else begin
        if (i_valid) overflow <= 1'b1;
        if (i_last) last_pend <= 1'b1;
        if (accept) begin
          row_data <= '0;
          row_mask <= '0;
          row_last <= 1'b0;
          done     <= row_last;
        end
      end
    end
  end

  assign o_ready         = (state == FILL);
  assign o_row_valid     = (state == HOLD);
  assign o_row_data      = row_data;
  assign o_row_mask      = row_mask;
  assign o_row_base_addr = base_addr;
  assign o_row_last      = row_last;
  assign o_done          = done;
  assign o_overflow      = overflow;

endmodule

// File: tb/tb_tile_row_packer.sv
// Directed bench for tile_row_packer (LANES=4, DATA_WIDTH=8, ADDR_WIDTH=8).
module tb_tile_row_packer;

  logic        clk = 1'b0;
  logic        nrst, reg_clear, valid, last, row_ready;
  logic [7:0]  data, data_addr;
  logic        ready, row_valid, row_last, done, overflow;
  logic [31:0] row_data;
  logic [3:0]  row_mask;
  logic [7:0]  row_base_addr;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tile_row_packer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LANES(4)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear),
    .i_valid(valid), .i_data(data), .i_data_addr(data_addr), .i_last(last),
    .o_ready(ready), .o_row_valid(row_valid), .i_row_ready(row_ready),
    .o_row_data(row_data), .o_row_mask(row_mask),
    .o_row_base_addr(row_base_addr), .o_row_last(row_last),
    .o_done(done), .o_overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a, input logic l);
    valid = 1'b1; data = d; data_addr = a; last = l;
    cycle();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_rvalid"}, 64'(row_valid), 64'd0);
    chk({tag, "_data"}, 64'(row_data), 64'd0);
    chk({tag, "_mask"}, 64'(row_mask), 64'd0);
    chk({tag, "_last"}, 64'(row_last), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    nrst = 1'b0; reg_clear = 1'b0; valid = 1'b0; last = 1'b0;
    row_ready = 1'b0; data = '0; data_addr = '0;
    cycle(); cycle();
    chk_idle("reset");
    chk("reset_done", 64'(done), 64'd0);
    nrst = 1'b1;
    cycle();

    // Full row, one-cycle latency, held stable under backpressure
    send(8'h11, 8'd8, 1'b0);
    send(8'h22, 8'd9, 1'b0);
    send(8'h33, 8'd10, 1'b0);
    chk("mid_row_ready", 64'(ready), 64'd1);
    send(8'h44, 8'd11, 1'b0);
    chk("full_rvalid", 64'(row_valid), 64'd1);
    chk("full_data", 64'(row_data), 64'h44332211);
    chk("full_mask", 64'(row_mask), 64'hF);
    chk("full_base", 64'(row_base_addr), 64'd8);
    chk("full_ready", 64'(ready), 64'd0);
    chk("full_last", 64'(row_last), 64'd0);
    repeat (5) cycle();
    chk("hold_rvalid", 64'(row_valid), 64'd1);
    chk("hold_data", 64'(row_data), 64'h44332211);
    chk("hold_mask", 64'(row_mask), 64'hF);
    chk("hold_base", 64'(row_base_addr), 64'd8);
    row_ready = 1'b1; cycle(); row_ready = 1'b0;
    chk_idle("accept1");
    chk("accept1_done", 64'(done), 64'd0);

    // Partial row flushed by read-done
    send(8'hAA, 8'd20, 1'b0);
    send(8'hBB, 8'd21, 1'b0);
    last = 1'b1; cycle(); last = 1'b0;
    chk("part_rvalid", 64'(row_valid), 64'd1);
    chk("part_data", 64'(row_data), 64'h0000BBAA);
    chk("part_mask", 64'(row_mask), 64'h3);
    chk("part_last", 64'(row_last), 64'd1);
    chk("part_base", 64'(row_base_addr), 64'd20);
    row_ready = 1'b1; cycle(); row_ready = 1'b0;
    chk("part_done", 64'(done), 64'd1);
    chk("part_ready", 64'(ready), 64'd1);
    chk("part_last_clr", 64'(row_last), 64'd0);
    cycle();
    chk("part_done_pulse", 64'(done), 64'd0);

    // Fourth word and read-done in the same cycle
    send(8'h01, 8'd40, 1'b0);
    send(8'h02, 8'd41, 1'b0);
    send(8'h03, 8'd42, 1'b0);
    send(8'h04, 8'd43, 1'b1);
    chk("fl_rvalid", 64'(row_valid), 64'd1);
    chk("fl_data", 64'(row_data), 64'h04030201);
    chk("fl_mask", 64'(row_mask), 64'hF);
    chk("fl_last", 64'(row_last), 64'd1);
    row_ready = 1'b1; cycle(); row_ready = 1'b0;
    chk("fl_done", 64'(done), 64'd1);
    cycle();

    // Read-done with an empty row: done only
    last = 1'b1; cycle(); last = 1'b0;
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_rvalid", 64'(row_valid), 64'd0);
    cycle();
    chk("empty_done_pulse", 64'(done), 64'd0);
    chk("empty_rvalid2", 64'(row_valid), 64'd0);

    // Word during HOLD is dropped and overflow sticks until clear
    send(8'h05, 8'd60, 1'b0);
    send(8'h06, 8'd61, 1'b0);
    send(8'h07, 8'd62, 1'b0);
    send(8'h08, 8'd63, 1'b0);
    send(8'h99, 8'd64, 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_data", 64'(row_data), 64'h08070605);
    chk("ovf_base", 64'(row_base_addr), 64'd60);
    // Read-done during HOLD is latched and replayed after acceptance
    last = 1'b1; cycle(); last = 1'b0;
    chk("latch_rvalid", 64'(row_valid), 64'd1);
    row_ready = 1'b1; cycle(); row_ready = 1'b0;
    chk("latch_accept_done", 64'(done), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    cycle();
    chk("latch_done", 64'(done), 64'd1);
    chk("latch_rvalid2", 64'(row_valid), 64'd0);
    reg_clear = 1'b1; cycle(); reg_clear = 1'b0;
    chk_idle("clear");

    // Asynchronous reset mid-row
    send(8'hE1, 8'd70, 1'b0);
    send(8'hE2, 8'd71, 1'b0);
    nrst = 1'b0; #1;
    chk_idle("rst_mid");
    chk("rst_mid_base", 64'(row_base_addr), 64'd0);
    cycle(); nrst = 1'b1; cycle();

    // Asynchronous reset while holding a row
    send(8'hD1, 8'd72, 1'b0);
    send(8'hD2, 8'd73, 1'b0);
    send(8'hD3, 8'd74, 1'b0);
    send(8'hD4, 8'd75, 1'b0);
    chk("pre_rst_rvalid", 64'(row_valid), 64'd1);
    nrst = 1'b0; #1;
    chk_idle("rst_hold");
    chk("rst_hold_done", 64'(done), 64'd0);
    cycle(); nrst = 1'b1; cycle();

    // Fresh row after reset
    send(8'hC1, 8'h50, 1'b0);
    send(8'hC2, 8'h51, 1'b0);
    send(8'hC3, 8'h52, 1'b0);
    send(8'hC4, 8'h53, 1'b0);
    chk("fresh_rvalid", 64'(row_valid), 64'd1);
    chk("fresh_data", 64'(row_data), 64'hC4C3C2C1);
    chk("fresh_mask", 64'(row_mask), 64'hF);
    chk("fresh_base", 64'(row_base_addr), 64'h50);
    chk("fresh_last", 64'(row_last), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tile_row_packer.md
TILE_ROW_PACKER -- requirements
Module: tile_row_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one buffer word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, buffer address width.
REQ-003 SHALL have parameter LANES, default 4, words per packed row (>=2).
REQ-004 SHALL have i_clk  input  1  clock, rising-edge; i_nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_reg_clear  input  1  synchronous clear, same effect as reset.
REQ-006 SHALL have i_valid  input  1  upstream word valid, from the tile reader valid-address flag.
REQ-007 SHALL have i_data  input  DATA_WIDTH  buffer read data aligned with i_valid.
REQ-008 SHALL have i_data_addr  input  ADDR_WIDTH  buffer address of i_data.
REQ-009 SHALL have i_last  input  1  upstream read-done; flush request.
REQ-010 SHALL have o_ready  output  1  upstream may present a word this cycle.
REQ-011 SHALL have o_row_valid  output  1  packed row available.
REQ-012 SHALL have i_row_ready  input  1  downstream accepts the row.
REQ-013 SHALL have o_row_data  output  LANES*DATA_WIDTH  packed row; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have o_row_mask  output  LANES  lane-k-valid bits.
REQ-015 SHALL have o_row_base_addr  output  ADDR_WIDTH  i_data_addr of the lane-0 word.
REQ-016 SHALL have o_row_last  output  1  row is the final row of the tile.
REQ-017 SHALL have o_done  output  1  one-cycle pulse when the tile is fully delivered.
REQ-018 SHALL have o_overflow  output  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement states FILL and HOLD; o_ready = 1 in FILL only; o_row_valid = 1 in HOLD only.
REQ-020 In FILL, a word with i_valid=1 SHALL be written to lane lane_cnt, set mask bit lane_cnt, increment lane_cnt (width clog2(LANES)); lane placement by count, not by address.
REQ-021 Lane 0 write SHALL capture i_data_addr into o_row_base_addr.
REQ-022 Word written when lane_cnt = LANES-1 SHALL move FILL->HOLD next cycle, mask all ones, lane_cnt wraps to 0.
REQ-023 i_last=1 in FILL with lane_cnt>0 (after any same-cycle word) SHALL move to HOLD with partial mask and o_row_last=1.
REQ-024 i_last=1 with the same-cycle word completing a row SHALL move to HOLD with full mask and o_row_last=1.
REQ-025 i_last=1 in FILL with lane_cnt=0 and no word SHALL pulse o_done next cycle and stay in FILL.
REQ-026 Unwritten lanes SHALL read zero in o_row_data.
REQ-027 In HOLD, o_row_data/mask/base_addr/last SHALL be stable until i_row_ready=1.
REQ-028 HOLD with i_row_ready=1 SHALL return to FILL next cycle, clear data, mask and o_row_last; if o_row_last was 1, o_done SHALL pulse that next cycle.
REQ-029 i_valid=1 while o_ready=0 SHALL drop the word and set o_overflow until reset/clear.
REQ-030 i_last in HOLD SHALL be latched and applied on return to FILL (REQ-023/025).
REQ-031 Latency: last word of a row to o_row_valid = 1 cycle.

Reset
REQ-032 On i_nrst low (any state) or i_reg_clear high SHALL force FILL, lane_cnt=0, all outputs 0 except o_ready=1, discarding partial/held rows and the latched i_last.

Verification
REQ-033 LANES=4, words 0x11,0x22,0x33,0x44 at addrs 8..11 -> next cycle o_row_valid=1, o_row_data=0x44332211, mask=4'b1111, base=8, o_ready=0.
REQ-034 Hold i_row_ready=0 for 5 cycles -> outputs unchanged; then i_row_ready=1 -> FILL next cycle, o_ready=1.
REQ-035 Words 0xAA,0xBB then i_last -> row 0x0000BBAA, mask=4'b0011, o_row_last=1; after accept, o_done pulses one cycle.
REQ-036 Fourth word and i_last same cycle -> full mask, o_row_last=1; i_last with empty row -> o_done only, no o_row_valid.
REQ-037 i_valid during HOLD -> word dropped, o_overflow=1 and stays 1 until i_reg_clear.
REQ-038 Assert i_nrst low mid-row and in HOLD -> all outputs 0, o_ready=1; next four words form a fresh row.
